seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per input word, minimum 2.
REQ-002 SHALL have parameter CNT_W, default 4: match counter width, minimum 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  word to scan, MSB first.
REQ-007 SHALL have port cfg_chain  input  1  1 = keep detector state across words, 0 = restart detector at S0 for each word.
REQ-008 SHALL have port in_ready  output  1  block can accept a word (high only in IDLE).
REQ-009 SHALL have port ser_x  output  1  bit currently applied to the detector.
REQ-010 SHALL have port match  output  1  one-cycle pulse when "101" completes on ser_x.
REQ-011 SHALL have port match_count  output  CNT_W  matches counted in the current or last word.
REQ-012 SHALL have port busy  output  1  high while in SHIFT.
REQ-013 SHALL have port done  output  1  one-cycle pulse; match_count is final this cycle.

Function
REQ-014 Control FSM SHALL have states IDLE, SHIFT and DONE.
REQ-015 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1.
- On accept: in_data is loaded into the shift register.
- The bit counter is set to WIDTH-1 and match_count is cleared to 0.
- cfg_chain is sampled; if it is 0, the detector is forced to S0.
- The FSM moves IDLE->SHIFT.
REQ-016 in_valid SHALL be ignored outside IDLE; in_data need not be held after accept.
REQ-017 In SHIFT, ser_x SHALL equal the shift register MSB; each edge shifts the register left by one, decrements the bit counter and advances the detector.
REQ-018 Detector transitions SHALL be (overlapping, Mealy), and the detector advances only in SHIFT:
- S0: x=1 -> S1, x=0 -> S0.
- S1: x=1 -> S1, x=0 -> S2.
- S2: x=1 -> S1, x=0 -> S0.
REQ-019 match SHALL be combinational: detector==S2 and ser_x=1 and state==SHIFT; it is 0 in IDLE and DONE.
REQ-020 match_count SHALL increment on each edge with match=1, saturating at 2^CNT_W-1 (no wrap).
REQ-021 SHIFT with bit counter 0 SHALL go to DONE on the next edge.
REQ-022 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-023 Timing from an accept at edge k:
- Bits are presented in cycles k+1 .. k+WIDTH.
- done is high in cycle k+WIDTH+1.
- in_ready rises in cycle k+WIDTH+2.
REQ-024 match_count SHALL hold its value through IDLE until the next accept; detector state SHALL hold through DONE and IDLE.
REQ-025 in_ready, busy and done SHALL be decoded from the FSM state only; in_ready SHALL NOT depend on in_valid.

Reset
REQ-026 On reset assertion, at any time including mid-SHIFT, the block SHALL asynchronously enter this state:
- FSM IDLE, detector S0, shift register 0, bit counter 0, match_count 0.
- Outputs: ser_x=0, match=0, busy=0, done=0, in_ready=1.
REQ-027 A word aborted by reset SHALL produce no done pulse, and no accept SHALL occur while reset is high.

Verification
REQ-028 WIDTH=8, cfg_chain=0, in_data=8'b10101101 -> match pulses on bits 2, 4 and 7; done in cycle k+9 with match_count=3.
REQ-029 cfg_chain=0 chaining check:
- word 8'b00000010 gives count 0.
- Then word 8'b10000000 gives count 0, no match.
- Repeating both words with cfg_chain=1 on the second -> match on its first bit, count 1.
REQ-030 CNT_W=2 saturation: word 8'b00000010, then 8'b10101010 with cfg_chain=1 -> 4 match pulses; match_count=3, with no wrap to 0.
REQ-031 Reset mid-operation: assert reset at bit 4 of a word -> all outputs at reset values immediately, no done; a new word after release scans normally.
REQ-032 Handshake:
- in_valid held high continuously -> accepts spaced exactly WIDTH+2 cycles apart.
- in_valid pulses during SHIFT or DONE are ignored; in_ready=0 in those cycles.

Source files
------------

// File: rtl/seq_scan_ctrl_if.sv
// Word-in / scan-out bundle for seq_scan_ctrl.
// The master drives words into the scanner; the slave is the scanner itself.
interface seq_scan_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             cfg_chain;
  logic             in_ready;
  logic             ser_x;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, cfg_chain,
    input  in_ready, ser_x, match, match_count, busy, done
  );

  modport slave (
    input  in_valid, in_data, cfg_chain,
    output in_ready, ser_x, match, match_count, busy, done
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serialises each accepted word MSB first through an overlapping "101" Mealy detector
// and counts the matches per word, saturating at the counter's maximum.
module seq_scan_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic           clk,
  input logic           reset,
  seq_scan_ctrl_if.slave bus
);
  localparam int unsigned BitCntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BitCntW-1:0] BitCntLast = BitCntW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {DetS0, DetS1, DetS2} det_e;

  state_e             state_q, state_d;
  det_e               det_q, det_d, det_adv;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic shifting;
  logic ser_x;
  logic match;

  assign shifting = (state_q == StShift);
  assign ser_x    = shifting & sr_q[WIDTH-1];
  assign match    = shifting && (det_q == DetS2) && ser_x;

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.busy        = shifting;
  assign bus.done        = (state_q == StDone);
  assign bus.ser_x       = ser_x;
  assign bus.match       = match;
  assign bus.match_count = cnt_q;

  always_comb begin
    det_adv = DetS0;
    case (det_q)
      DetS0:   det_adv = ser_x ? DetS1 : DetS0;
      DetS1:   det_adv = ser_x ? DetS1 : DetS2;
      DetS2:   det_adv = ser_x ? DetS1 : DetS0;
      default: det_adv = DetS0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    det_d     = det_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        // in_ready is high throughout IDLE, so in_valid alone marks an accept.
        if (bus.in_valid) begin
          sr_d      = bus.in_data;
          bit_cnt_d = BitCntLast;
          cnt_d     = '0;
          if (!bus.cfg_chain) det_d = DetS0;
          state_d   = StShift;
        end
      end
      StShift: begin
        sr_d      = {sr_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q - 1'b1;
        det_d     = det_adv;
        if (match && (cnt_q != CntMax)) cnt_d = cnt_q + 1'b1;
        if (bit_cnt_q == '0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      det_q     <= DetS0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      det_q     <= det_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: a 4-bit-counter instance and a 2-bit-counter instance
// share the same stimulus; expected bits, pulses and counts are hand-derived.
module tb_seq_scan_ctrl;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic reset;

  seq_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(4)) bus ();
  seq_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(2)) bus_sat ();

  assign bus_sat.in_valid  = bus.in_valid;
  assign bus_sat.in_data   = bus.in_data;
  assign bus_sat.cfg_chain = bus.cfg_chain;

  seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       chain;
    logic [7:0] mask;  // mask[i] = match expected while bit i (MSB first) is presented
    int         cnt;
  } vec_t;

  vec_t vecs[9];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_match"}, 32'(bus.match), 32'd0);
    check({tag, "_ser_x"}, 32'(bus.ser_x), 32'd0);
    check({tag, "_count"}, 32'(bus.match_count), 32'd0);
    check({tag, "_count_sat"}, 32'(bus_sat.match_count), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout actual=0 required=1", tag);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_word(input string tag, input logic [7:0] data, input logic chain,
                          input logic [7:0] mask, input int cnt);
    int sat;
    sat = (cnt > 3) ? 3 : cnt;
    wait_ready(tag);
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.cfg_chain = chain;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check($sformatf("%s_busy_b%0d", tag, i), 32'(bus.busy), 32'd1);
      check($sformatf("%s_ready_b%0d", tag, i), 32'(bus.in_ready), 32'd0);
      check($sformatf("%s_ser_x_b%0d", tag, i), 32'(bus.ser_x), 32'(data[WIDTH-1-i]));
      check($sformatf("%s_match_b%0d", tag, i), 32'(bus.match), 32'(mask[i]));
      // Garbage on the inputs while not in IDLE must be ignored.
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      bus.cfg_chain = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_done_match"}, 32'(bus.match), 32'd0);
    check({tag, "_count"}, 32'(bus.match_count), 32'(cnt));
    check({tag, "_count_sat"}, 32'(bus_sat.match_count), 32'(sat));
    bus.in_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_count_hold"}, 32'(bus.match_count), 32'(cnt));
  endtask

  initial begin
    int rise_cycle[$];
    int done_seen;
    logic prev_busy;

    //        data          chain  mask          count
    vecs[0] = '{8'b10101101, 1'b0, 8'b1001_0100, 3};
    vecs[1] = '{8'b00000010, 1'b0, 8'b0000_0000, 0};
    vecs[2] = '{8'b10000000, 1'b0, 8'b0000_0000, 0};
    vecs[3] = '{8'b00000010, 1'b0, 8'b0000_0000, 0};
    vecs[4] = '{8'b10000000, 1'b1, 8'b0000_0001, 1};
    vecs[5] = '{8'b00000010, 1'b0, 8'b0000_0000, 0};
    vecs[6] = '{8'b10101010, 1'b1, 8'b0101_0101, 4};
    vecs[7] = '{8'b11111111, 1'b1, 8'b0000_0001, 1};
    vecs[8] = '{8'b01010101, 1'b0, 8'b1010_1000, 3};

    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hff;
    bus.cfg_chain = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 9; v++) run_word($sformatf("vec%0d", v), vecs[v].data, vecs[v].chain,
                                         vecs[v].mask, vecs[v].cnt);

    // Reset in the middle of a word, while bit 4 (a match bit) is on ser_x.
    wait_ready("rst");
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'b10101101;
    bus.cfg_chain = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    check("rst_pre_match", 32'(bus.match), 32'd1);
    #1 reset = 1'b1;
    bus.in_valid = 1'b1;
    #1 check_reset_outputs("rst_async");
    repeat (3) begin
      @(negedge clk);
      check("rst_no_accept", 32'(bus.busy), 32'd0);
    end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    done_seen    = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("rst_no_done", 32'(done_seen), 32'd0);
    // Chained word: only matches on its first bit if the detector survived reset.
    run_word("post_rst", 8'b10000000, 1'b1, 8'b0000_0000, 0);

    // in_valid held high: accepts must be exactly WIDTH+2 cycles apart.
    wait_ready("cont");
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5a;
    bus.cfg_chain = 1'b0;
    prev_busy     = bus.busy;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.busy && !prev_busy) rise_cycle.push_back(c);
      prev_busy = bus.busy;
    end
    bus.in_valid = 1'b0;
    check("cont_accepts_ge3", 32'(rise_cycle.size() >= 3), 32'd1);
    for (int i = 1; i < rise_cycle.size(); i++)
      check($sformatf("cont_spacing%0d", i), 32'(rise_cycle[i] - rise_cycle[i-1]),
            32'(WIDTH + 2));
    wait_ready("cont_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
